// File: rtl/hex_parser.sv
// ASCII hex tokenizer: accumulates hex digits into a word and emits one token
// (value, digit count, overflow, terminating byte) for every non-hex byte.
module hex_parser #(
  parameter int WIDTH = 32,
  localparam int MAX_DIGITS = WIDTH / 4,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value,
  output logic [CW-1:0]    out_digits,
  output logic             out_overflow,
  output logic [7:0]       out_term,
  output logic             busy
);

  typedef enum logic {IDLE, DIGITS} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             emit;
  logic [4:0]       dec;

  // {is_hex, nibble}; anything outside 0-9 / a-f / A-F is a terminator.
  function automatic logic [4:0] decode_hex(input logic [7:0] b);
    logic [4:0] r;
    r = '0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  assign dec = decode_hex(in_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;
    if (in_valid) begin
      if (dec[4]) begin
        // Oldest digits shift out the top, so the newest MAX_DIGITS survive.
        acc_d   = {acc_q[WIDTH-5:0], dec[3:0]};
        state_d = DIGITS;
        if (cnt_q < CW'(MAX_DIGITS))
          cnt_d = cnt_q + 1'b1;
        else
          ovf_d = 1'b1;
      end else begin
        emit    = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = IDLE;
      end
    end
  end

  // Token register stage: outputs hold their last token between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_digits   <= '0;
      out_overflow <= 1'b0;
      out_term     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_valid <= emit;
      if (emit) begin
        out_value    <= acc_q;
        out_digits   <= cnt_q;
        out_overflow <= ovf_q;
        out_term     <= in_data;
      end
    end
  end

  assign busy = (state_q == DIGITS);

endmodule

// File: tb/tb_hex_parser.sv
// Bench for hex_parser: directed plan steps plus random byte streams, checked
// against a token-level reference model.
module tb_hex_parser;
  localparam int W    = 32;
  localparam int MAXD = W / 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         out_valid;
  logic [W-1:0] out_value;
  logic [3:0]   out_digits;
  logic         out_overflow;
  logic [7:0]   out_term;
  logic         busy;

  int checks = 0;
  int failures = 0;

  longint unsigned m_val = 0;
  int              m_cnt = 0;
  bit              m_ovf = 0;
  bit              e_valid = 0;
  longint unsigned e_value = 0;
  int              e_digits = 0;
  bit              e_ovf = 0;
  logic [7:0]      e_term = 0;

  hex_parser #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_value(out_value), .out_digits(out_digits),
    .out_overflow(out_overflow), .out_term(out_term), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit tb_hex(input logic [7:0] b, output logic [3:0] n);
    string lo = "0123456789abcdef";
    string up = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++)
      if (b == lo[i] || b == up[i]) begin
        n = 4'(i);
        return 1'b1;
      end
    n = 4'd0;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare every output.
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    logic [3:0] n;
    reset = r; in_valid = v; in_data = d;
    e_valid = 0;
    if (r) begin
      m_val = 0; m_cnt = 0; m_ovf = 0;
      e_value = 0; e_digits = 0; e_ovf = 0; e_term = 0;
    end else if (v) begin
      if (tb_hex(d, n)) begin
        m_val = ((m_val * 16) + n) % (64'd1 << W);
        if (m_cnt < MAXD) m_cnt++;
        else m_ovf = 1;
      end else begin
        e_valid = 1; e_value = m_val; e_digits = m_cnt; e_ovf = m_ovf; e_term = d;
        m_val = 0; m_cnt = 0; m_ovf = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("out_value", 64'(out_value), e_value);
    chk("out_digits", 64'(out_digits), 64'(e_digits));
    chk("out_overflow", 64'(out_overflow), 64'(e_ovf));
    chk("out_term", 64'(out_term), 64'(e_term));
    chk("busy", 64'(busy), 64'(m_cnt > 0));
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(0, 1, s[i]);
  endtask

  initial begin
    logic [7:0] bnd [7];
    string hexset;
    hexset = "0123456789abcdefABCDEF";
    bnd = '{8'h2F, 8'h3A, 8'h40, 8'h47, 8'h60, 8'h67, 8'hFF};

    step(1, 0, 8'h00);
    step(1, 1, 8'h31);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    send_str("12aB");
    chk("busy_in_digits", 64'(busy), 64'd1);
    step(0, 1, 8'h20);
    chk("tok1_value", 64'(out_value), 64'h12AB);
    chk("tok1_digits", 64'(out_digits), 64'd4);
    chk("tok1_busy_low", 64'(busy), 64'd0);

    send_str("r\n");
    chk("bare_term", 64'(out_term), 64'h0A);

    send_str("0123456789\r");
    chk("ovf_value", 64'(out_value), 64'h23456789);
    chk("ovf_flag", 64'(out_overflow), 64'd1);
    chk("ovf_digits", 64'(out_digits), 64'd8);
    send_str("5 ");
    chk("after_ovf_flag", 64'(out_overflow), 64'd0);
    chk("after_ovf_value", 64'(out_value), 64'd5);

    send_str("ff");
    step(1, 0, 8'h00);
    send_str("3\n");
    chk("post_reset_value", 64'(out_value), 64'd3);

    step(0, 1, "d");
    repeat (3) step(0, 0, 8'h41);
    step(0, 1, "e");
    step(0, 0, 8'h20);
    step(0, 1, "g");
    chk("gap_value", 64'(out_value), 64'hDE);
    step(0, 0, 8'h20);
    chk("gap_one_pulse", 64'(out_valid), 64'd0);

    for (int i = 0; i < 7; i++) begin
      step(0, 1, bnd[i]);
      chk("boundary_token", 64'(out_valid), 64'd1);
      step(0, 1, "1");
    end
    step(0, 1, 8'h0D);
    chk("boundary_last_value", 64'(out_value), 64'd1);

    for (int i = 0; i < 2000; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = hexset[$urandom_range(0, 21)];
        6:       b = 8'h20;
        default: b = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
